dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- MEM-stage load/store initiator that drives the synchronous word-addressed data memory (MemRead/MemWrite/address/DataToWrite/ReadData, sampled on posedge clk).
- Converts pipeline byte-address requests (byte/half/word, signed/unsigned) into word accesses.
- Absorbs the memory's one-cycle read latency and performs read-modify-write for sub-word stores.
- Holds off the pipeline through req_ready.

Parameters:
- WORD_ADDR_BITS, 11, word-index width; 2^11 = 2048 words, matching data memory depth.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  unit can accept; pipeline stalls while low
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  formatted load data
- resp_fault  out  1  misaligned-access flag, valid with resp_valid
- mem_address  out  32  word index: {zeros, req_addr[WORD_ADDR_BITS+1:2]}
- mem_wdata  out  32  to DataToWrite
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_rdata  in  32  from ReadData

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0.
  - Latched request regs = 0.
  - mem_read=mem_write=0 immediately.
  - A pending write is dropped. Reset during WR before the edge means memory is not written.
- Memory-side outputs decode only from state and latched registers. No combinational path from req_* to mem_*.
- mem_read and mem_write are never both 1.
- Lane map (little-endian): byte n = bits 8n+7:8n, selected by addr[1:0]; halfword by addr[1].
- FSM:
  - IDLE: req_ready=1. On req_valid, latch request:
    - load -> RD
    - word store -> WR
    - byte/half store -> RD (RMW)
  - RD: mem_read=1 at latched index; memory samples at the next edge -> CAP.
  - CAP: mem_read=0; mem_rdata valid.
    - Load: extract lane, extend per size/req_unsigned, register into resp_rdata, set resp_valid -> IDLE.
    - RMW: merge req_wdata low byte/half into the read word's selected lane, hold in merge_reg -> WR.
  - WR: mem_write=1; mem_wdata = merge_reg (RMW) or req_wdata (word). Memory writes at the next edge. Set resp_valid -> IDLE.
- req_ready=0 in RD, CAP and WR.
- resp_valid is high for exactly one cycle, the IDLE cycle after completion. A new request may be accepted in that same cycle (back-to-back).
- Latency (acceptance edge = E0):
  - Load: resp_valid during the cycle after E2.
  - Word store: resp_valid during the cycle after E1; memory updated at E1.
  - Sub-word store: resp_valid during the cycle after E3.
- resp_rdata holds its last load value on stores and until the next load completes.
- Address wrap: bits above WORD_ADDR_BITS+1 are ignored, so the index wraps modulo 2^WORD_ADDR_BITS.
- mem_address upper bits are always 0.
- req_valid low in IDLE: no activity; all mem strobes 0.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is accepted with no memory access.
  - resp_valid and resp_fault=1 are asserted in the following cycle; resp_rdata unchanged.
- Undefined:
  - resp_fault tied 0.
  - Low address bits are ignored (half uses addr[1] only; word uses index only).

Test Plan:
- Memory word 4 = 0x8899AABB; signed byte load at 0x12 -> resp_rdata=0xFFFFFF99; unsigned -> 0x00000099; resp_valid 3 cycles after acceptance; mem_read high exactly 1 cycle.
- Signed half load at 0x12 -> 0xFFFF8899; unsigned half at 0x10 -> 0x0000AABB.
- Store byte req_wdata=0x0000005A to 0x11 -> word 4 becomes 0x88995ABB; sequence RD, CAP, WR; req_ready low 3 cycles.
- Word store 0xDEADBEEF to 0x20, then immediate word load from 0x20 accepted in the resp_valid cycle -> word 8 = 0xDEADBEEF, load returns 0xDEADBEEF.
- With DMEM_ALIGN_CHECK_EN: word load at 0x13 -> resp_fault=1, resp_valid 1 cycle after acceptance, mem_read never asserted. Without the macro -> reads word 4.
- Assert rst_n low mid-RMW in WR -> mem_write drops immediately, word unchanged, req_ready=1 after release, resp_valid not asserted.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Turns MEM-stage byte-addressed load/store requests (byte, half, word; signed
// or unsigned) into accesses on a synchronous word-addressed data memory. It
// absorbs the memory's one-cycle read latency, does read-modify-write for
// sub-word stores, and stalls the pipeline through req_ready.
//
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word
// requests complete right away with resp_fault=1 and never touch memory. When
// it is undefined, resp_fault is tied low and the low address bits are ignored.
module dmem_access_unit #(
  parameter int WORD_ADDR_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CAP  = 2'b10,
    WR   = 2'b11
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  state_t                    stateReg;
  state_t                    stateNext;
  logic                      acceptReq;
  logic                      faultReq;
  logic                      misaligned;

  // Latched request. mergeReg holds the store data from acceptance onwards
  // and, for sub-word stores, is replaced by the merged word in CAP.
  logic [WORD_ADDR_BITS-1:0] idxReg;
  logic [1:0]                offReg;
  logic [1:0]                sizeReg;
  logic                      unsReg;
  logic                      weReg;
  logic [31:0]               mergeReg;

  logic                      respValidReg;
  logic [31:0]               respRdataReg;

  // Address bits above the word index are ignored so the index wraps.
  logic                      unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:WORD_ADDR_BITS+2];

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'b00:   b = word[7:0];
          2'b01:   b = word[15:8];
          2'b10:   b = word[23:16];
          2'b11:   b = word[31:24];
          default: b = word[7:0];
        endcase
        r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      end
      SIZE_HALF: begin
        if (off[1]) begin
          h = word[31:16];
        end else begin
          h = word[15:0];
        end
        r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Drop the low byte/half of the store data into the addressed lane.
  function automatic logic [31:0] mergeStore(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          2'b11:   r[31:24] = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

`ifdef DMEM_ALIGN_CHECK_EN
  logic respFaultReg;

  // Misaligned half/word requests are answered with a fault instead of an access.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = req_addr[0];
      default:   misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign resp_fault = respFaultReg;
`else
  assign misaligned = 1'b0;
  assign resp_fault = 1'b0;
`endif

  // State register; reset forces IDLE so the memory strobes drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic and state-decoded handshake and memory strobes.
  always_comb begin
    stateNext = stateReg;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    acceptReq = 1'b0;
    faultReq  = 1'b0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned) begin
            faultReq  = 1'b1;
            stateNext = IDLE;
          end else begin
            acceptReq = 1'b1;
            if (req_we && req_size[1]) begin
              stateNext = WR;
            end else begin
              stateNext = RD;
            end
          end
        end else begin
          stateNext = IDLE;
        end
      end
      RD: begin
        mem_read  = 1'b1;
        stateNext = CAP;
      end
      CAP: begin
        if (weReg) begin
          stateNext = WR;
        end else begin
          stateNext = IDLE;
        end
      end
      WR: begin
        mem_write = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request latch, read-modify-write merge and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idxReg       <= {WORD_ADDR_BITS{1'b0}};
      offReg       <= 2'b00;
      sizeReg      <= 2'b00;
      unsReg       <= 1'b0;
      weReg        <= 1'b0;
      mergeReg     <= 32'h0000_0000;
      respValidReg <= 1'b0;
      respRdataReg <= 32'h0000_0000;
`ifdef DMEM_ALIGN_CHECK_EN
      respFaultReg <= 1'b0;
`endif
    end else begin
      respValidReg <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      respFaultReg <= 1'b0;
`endif
      case (stateReg)
        IDLE: begin
          if (acceptReq) begin
            idxReg   <= req_addr[WORD_ADDR_BITS+1:2];
            offReg   <= req_addr[1:0];
            sizeReg  <= req_size;
            unsReg   <= req_unsigned;
            weReg    <= req_we;
            mergeReg <= req_wdata;
          end else if (faultReq) begin
            respValidReg <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
            respFaultReg <= 1'b1;
`endif
          end else begin
            mergeReg <= mergeReg;
          end
        end
        CAP: begin
          if (weReg) begin
            mergeReg <= mergeStore(mem_rdata, mergeReg, offReg, sizeReg);
          end else begin
            respRdataReg <= extractLoad(mem_rdata, offReg, sizeReg, unsReg);
            respValidReg <= 1'b1;
          end
        end
        WR: begin
          respValidReg <= 1'b1;
        end
        default: begin
          respValidReg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address = {{(32-WORD_ADDR_BITS){1'b0}}, idxReg};
  assign mem_wdata   = mergeReg;
  assign resp_valid  = respValidReg;
  assign resp_rdata  = respRdataReg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural synchronous
// word-addressed memory (registered read, write on posedge).
module tb_dmem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:2047];

  int vectors;
  int miscompares;

  dmem_access_unit #(.WORD_ADDR_BITS(11)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data memory: write and registered read on the rising edge.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[10:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_address[10:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it until resp_valid (bounded to 10 cycles).
  // lat counts cycles after the acceptance edge; 99 means no response.
  task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int nRd, output int nWr, output int nBusy,
                       output logic [31:0] seenAddr, output logic [31:0] rdata,
                       output logic fault);
    lat = 99; nRd = 0; nWr = 0; nBusy = 0;
    seenAddr = 32'hFFFF_FFFF; rdata = 32'hFFFF_FFFF; fault = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_read)  begin nRd++; seenAddr = mem_address; end
      if (mem_write) begin nWr++; seenAddr = mem_address; end
      if (!req_ready) nBusy++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; fault = resp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat, nRd, nWr, nBusy;
  logic [31:0] sa, rd;
  logic        flt;
  logic        sawResp;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_address, 32'h0);
    rst_n = 1'b1;

    // Word store 0x8899AABB to 0x10 -> word 4
    doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("sw_lat", lat, 32'd2);
    check("sw_nrd", nRd, 32'd0);
    check("sw_nwr", nWr, 32'd1);
    check("sw_busy", nBusy, 32'd1);
    check("sw_addr", sa, 32'd4);
    check("sw_rdata_hold", rd, 32'h0);
    check("sw_mem", mem[4], 32'h8899AABB);

    // Signed byte load at 0x12
    doReq(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("lb_lat", lat, 32'd3);
    check("lb_nrd", nRd, 32'd1);
    check("lb_nwr", nWr, 32'd0);
    check("lb_busy", nBusy, 32'd2);
    check("lb_addr", sa, 32'd4);
    check("lb_data", rd, 32'hFFFFFF99);
    check("lb_fault", {31'd0, flt}, 32'd0);
    @(negedge clk);
    check("lb_pulse", {31'd0, resp_valid}, 32'd0);
    check("lb_hold", resp_rdata, 32'hFFFFFF99);

    // Unsigned byte / signed half / unsigned half loads
    doReq(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("lbu_data", rd, 32'h00000099);
    doReq(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("lh_data", rd, 32'hFFFF8899);
    doReq(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("lhu_data", rd, 32'h0000AABB);

    // Byte store 0x5A to 0x11 (read-modify-write)
    doReq(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("sb_lat", lat, 32'd4);
    check("sb_busy", nBusy, 32'd3);
    check("sb_nrd", nRd, 32'd1);
    check("sb_nwr", nWr, 32'd1);
    check("sb_mem", mem[4], 32'h88995ABB);
    check("sb_rdata_hold", rd, 32'h0000AABB);

    // Half store to 0x12; only the low 16 bits of the data are used
    doReq(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("sh_mem", mem[4], 32'h12345ABB);

    // Size 11 behaves as word; address 0x2010 wraps to word 4
    doReq(1'b0, 2'b11, 1'b0, 32'h0000_2010, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("wrap_addr", sa, 32'd4);
    check("wrap_data", rd, 32'h12345ABB);

    // Unsigned byte load of the top lane
    doReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("lbu3_data", rd, 32'h00000012);

    // Back-to-back: word store to 0x20, load from 0x20 accepted in resp_valid cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_st_valid", {31'd0, resp_valid}, 32'd1);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_pulse", {31'd0, resp_valid}, 32'd0);
    lat = 99; rd = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      if (resp_valid) begin lat = c; rd = resp_rdata; break; end
      @(negedge clk);
    end
    check("b2b_ld_lat", lat, 32'd3);
    check("b2b_ld_data", rd, 32'hDEADBEEF);
    check("b2b_mem", mem[8], 32'hDEADBEEF);

    // Misaligned word load at 0x13
    doReq(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_lat", lat, 32'd1);
    check("mis_fault", {31'd0, flt}, 32'd1);
    check("mis_nrd", nRd, 32'd0);
    check("mis_rdata_hold", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("mis_fault_pulse", {31'd0, resp_fault}, 32'd0);
`else
    check("mis_lat", lat, 32'd3);
    check("mis_fault", {31'd0, flt}, 32'd0);
    check("mis_data", rd, 32'h12345ABB);
    doReq(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, nRd, nWr, nBusy, sa, rd, flt);
    check("mis_half_data", rd, 32'h00005ABB);
`endif

    // Reset asserted during the write cycle of a read-modify-write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h000000FF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (mem_write) break;
      @(negedge clk);
    end
    check("rmw_wr_seen", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_wr", {31'd0, mem_write}, 32'd0);
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    check("rmw_rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    check("rmw_rst_mem", mem[4], 32'h12345ABB);
    rst_n = 1'b1;
    sawResp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || !req_ready || mem_write || mem_read) sawResp = 1'b1;
      @(negedge clk);
    end
    check("rmw_post_quiet", {31'd0, sawResp}, 32'd0);
    check("rmw_post_mem", mem[4], 32'h12345ABB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
